// File: rtl/alu_complete_arbiter_pkg.sv
// Shared types and sizing for the ALU complete-stage arbiter.
// The completion packet is the one fu_alu already produces.
package alu_complete_arbiter_pkg;

   localparam int unsigned NUM_ALU_FU = 4;
   localparam int unsigned NUM_CDB    = 3;

   typedef struct packed {
      logic [31:0] target_pc;
      logic [31:0] dest_value;
      logic [4:0]  rob_idx;
      logic        take_branch;
      logic        halt;
      logic        rd_mem;
      logic        wr_mem;
   } fu_complete_packet_t;

endpackage

// File: rtl/alu_complete_arbiter_rr_multi_select.sv
// Combinational round-robin picker: grants up to CDB_WIDTH requesters starting at ptr
// and packs them into consecutive slot numbers in scan order.
module alu_complete_arbiter_rr_multi_select #(
   parameter int unsigned NUM_FU    = 4,
   parameter int unsigned CDB_WIDTH = 3,
   localparam int unsigned PtrW     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
   localparam int unsigned SlotW    = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1
) (
   input  logic [NUM_FU-1:0]            req,
   input  logic [PtrW-1:0]              ptr,
   output logic [NUM_FU-1:0]            grant,
   output logic [NUM_FU-1:0][SlotW-1:0] slot_idx,
   output logic [PtrW-1:0]              last_grant_idx,
   output logic                         any_grant
);

   always_comb begin
      int unsigned     cnt;
      logic [PtrW-1:0] idx;
      grant          = '0;
      slot_idx       = '0;
      last_grant_idx = '0;
      any_grant      = 1'b0;
      cnt            = 0;
      idx            = '0;
      for (int unsigned k = 0; k < NUM_FU; k++) begin
         idx = PtrW'((32'(ptr) + k) % NUM_FU);
         if (req[idx] && (cnt < CDB_WIDTH)) begin
            grant[idx]     = 1'b1;
            slot_idx[idx]  = SlotW'(cnt);
            last_grant_idx = idx;
            any_grant      = 1'b1;
            cnt            = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/alu_complete_arbiter.sv
// Shares the CDB slots among the ALU lanes; losing lanes park in a one-entry hold
// register and stall their FU until granted. CDB outputs are registered.
module alu_complete_arbiter
   import alu_complete_arbiter_pkg::*;
#(
   parameter int unsigned NUM_FU    = NUM_ALU_FU,
   parameter int unsigned CDB_WIDTH = NUM_CDB
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 squash,
   input  logic [NUM_FU-1:0]                    fu_valid_in,
   input  fu_complete_packet_t [NUM_FU-1:0]     fu_packet_in,
   output logic [NUM_FU-1:0]                    complete_stall,
   output logic [CDB_WIDTH-1:0]                 cdb_valid,
   output fu_complete_packet_t [CDB_WIDTH-1:0]  cdb_packet
);

   localparam int unsigned PtrW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int unsigned SlotW = (CDB_WIDTH > 1) ? $clog2(CDB_WIDTH) : 1;

   logic [NUM_FU-1:0]                   hold_valid_q, hold_valid_d;
   fu_complete_packet_t [NUM_FU-1:0]    hold_pkt_q, hold_pkt_d;
   logic [PtrW-1:0]                     rr_ptr_q, rr_ptr_d;
   logic [CDB_WIDTH-1:0]                cdb_valid_q, cdb_valid_d;
   fu_complete_packet_t [CDB_WIDTH-1:0] cdb_packet_q, cdb_packet_d;

   logic [NUM_FU-1:0]                   cand_valid;
   fu_complete_packet_t [NUM_FU-1:0]    cand_pkt;
   logic [NUM_FU-1:0]                   grant;
   logic [NUM_FU-1:0][SlotW-1:0]        slot_idx;
   logic [PtrW-1:0]                     last_grant_idx;
   logic                                any_grant;

   // A held packet always takes the lane's candidate spot; the stalled FU input is ignored.
   always_comb begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         cand_valid[i] = hold_valid_q[i] | fu_valid_in[i];
         cand_pkt[i]   = hold_valid_q[i] ? hold_pkt_q[i] : fu_packet_in[i];
      end
   end

   alu_complete_arbiter_rr_multi_select #(
      .NUM_FU    (NUM_FU),
      .CDB_WIDTH (CDB_WIDTH)
   ) u_select (
      .req            (cand_valid),
      .ptr            (rr_ptr_q),
      .grant          (grant),
      .slot_idx       (slot_idx),
      .last_grant_idx (last_grant_idx),
      .any_grant      (any_grant)
   );

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_pkt_d   = hold_pkt_q;
      rr_ptr_d     = rr_ptr_q;
      cdb_valid_d  = '0;
      cdb_packet_d = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            cdb_valid_d[slot_idx[i]]  = 1'b1;
            cdb_packet_d[slot_idx[i]] = cand_pkt[i];
            hold_valid_d[i]           = 1'b0;
         end else if (cand_valid[i]) begin
            hold_valid_d[i] = 1'b1;
            hold_pkt_d[i]   = cand_pkt[i];
         end
      end
      if (any_grant) begin
         rr_ptr_d = (last_grant_idx == PtrW'(NUM_FU - 1)) ? '0 : last_grant_idx + PtrW'(1);
      end
      // Flush drops everything in flight but keeps the fairness pointer where it was.
      if (squash) begin
         hold_valid_d = '0;
         cdb_valid_d  = '0;
         cdb_packet_d = '0;
         rr_ptr_d     = rr_ptr_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_valid_q <= '0;
         hold_pkt_q   <= '0;
         rr_ptr_q     <= '0;
         cdb_valid_q  <= '0;
         cdb_packet_q <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_pkt_q   <= hold_pkt_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_packet_q <= cdb_packet_d;
      end
   end

   assign complete_stall = hold_valid_q;
   assign cdb_valid      = cdb_valid_q;
   assign cdb_packet     = cdb_packet_q;

endmodule
